// File: rtl/axi_decoder.sv
// ---------------------------------------------------------------------------
// axi_decoder
// Routes one upstream AXI4-Lite slave port to one of two downstream master
// ports. The decode is a base/mask match. When an address hits both
// windows, m0 is used.
//
// The write and read paths are two independent FSMs. Each path holds at
// most one outstanding transaction.
//
// Optional feature macro: AXI_DECODER_DECERR_EN
//   - Defined: the decoder answers an unmapped transaction itself with
//     DECERR (2'b11). No downstream port sees any traffic for it.
//   - Undefined: an unmapped address is sent to m1, the default slave.
//
// Ports
//   clk, reset      : clock, asynchronous active-high reset
//   s_aw*/s_w*/s_b* : upstream write address / data / response
//   s_ar*/s_r*      : upstream read address / data
//   m0_*, m1_*      : downstream AXI4-Lite master ports, one per slave
// ---------------------------------------------------------------------------
module axi_decoder #(
  parameter int                ADDR_W  = 32,
  parameter int                DATA_W  = 32,
  parameter logic [ADDR_W-1:0] M0_BASE = 32'h0000_0000,
  parameter logic [ADDR_W-1:0] M0_MASK = 32'hFFFF_0000,
  parameter logic [ADDR_W-1:0] M1_BASE = 32'h0001_0000,
  parameter logic [ADDR_W-1:0] M1_MASK = 32'hFFFF_0000
) (
  input  logic                clk,
  input  logic                reset,
  // upstream
  input  logic                s_awvalid,
  input  logic [ADDR_W-1:0]   s_awaddr,
  output logic                s_awready,
  input  logic                s_wvalid,
  input  logic [DATA_W-1:0]   s_wdata,
  input  logic [DATA_W/8-1:0] s_wstrb,
  output logic                s_wready,
  output logic                s_bvalid,
  output logic [1:0]          s_bresp,
  input  logic                s_bready,
  input  logic                s_arvalid,
  input  logic [ADDR_W-1:0]   s_araddr,
  output logic                s_arready,
  output logic                s_rvalid,
  output logic [DATA_W-1:0]   s_rdata,
  output logic [1:0]          s_rresp,
  input  logic                s_rready,
  // downstream port 0
  output logic                m0_awvalid,
  output logic [ADDR_W-1:0]   m0_awaddr,
  input  logic                m0_awready,
  output logic                m0_wvalid,
  output logic [DATA_W-1:0]   m0_wdata,
  output logic [DATA_W/8-1:0] m0_wstrb,
  input  logic                m0_wready,
  input  logic                m0_bvalid,
  input  logic [1:0]          m0_bresp,
  output logic                m0_bready,
  output logic                m0_arvalid,
  output logic [ADDR_W-1:0]   m0_araddr,
  input  logic                m0_arready,
  input  logic                m0_rvalid,
  input  logic [DATA_W-1:0]   m0_rdata,
  input  logic [1:0]          m0_rresp,
  output logic                m0_rready,
  // downstream port 1
  output logic                m1_awvalid,
  output logic [ADDR_W-1:0]   m1_awaddr,
  input  logic                m1_awready,
  output logic                m1_wvalid,
  output logic [DATA_W-1:0]   m1_wdata,
  output logic [DATA_W/8-1:0] m1_wstrb,
  input  logic                m1_wready,
  input  logic                m1_bvalid,
  input  logic [1:0]          m1_bresp,
  output logic                m1_bready,
  output logic                m1_arvalid,
  output logic [ADDR_W-1:0]   m1_araddr,
  input  logic                m1_arready,
  input  logic                m1_rvalid,
  input  logic [DATA_W-1:0]   m1_rdata,
  input  logic [1:0]          m1_rresp,
  output logic                m1_rready
);

  typedef enum logic [1:0] {W_IDLE, W_FWD, W_RESP} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_FWD, R_RESP} r_state_t;
  typedef enum logic [1:0] {SEL_M0, SEL_M1, SEL_ERR} sel_t;

  // m0 is checked first, so an overlap of the two windows resolves to m0.
  function automatic sel_t decode(input logic [ADDR_W-1:0] addr);
    if ((addr & M0_MASK) == M0_BASE) return SEL_M0;
    if ((addr & M1_MASK) == M1_BASE) return SEL_M1;
`ifdef AXI_DECODER_DECERR_EN
    return SEL_ERR;
`else
    return SEL_M1;
`endif
  endfunction

  w_state_t          w_state_reg, w_state_next;
  r_state_t          r_state_reg, r_state_next;
  sel_t              w_sel_reg, r_sel_reg;
  logic [ADDR_W-1:0] awaddr_reg, araddr_reg;
  logic              aw_done_reg, w_done_reg;
  logic              aw_hs, w_hs;

  // Address and write data go to both ports unqualified.
  // Only the valid signals are steered to the selected port.
  assign m0_awaddr = awaddr_reg;
  assign m1_awaddr = awaddr_reg;
  assign m0_araddr = araddr_reg;
  assign m1_araddr = araddr_reg;
  assign m0_wdata  = s_wdata;
  assign m1_wdata  = s_wdata;
  assign m0_wstrb  = s_wstrb;
  assign m1_wstrb  = s_wstrb;

  // ---------------- write path ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      w_state_reg <= W_IDLE;
      w_sel_reg   <= SEL_M0;
      awaddr_reg  <= '0;
      aw_done_reg <= 1'b0;
      w_done_reg  <= 1'b0;
    end else begin
      w_state_reg <= w_state_next;
      if (w_state_reg == W_IDLE && s_awvalid) begin
        awaddr_reg  <= s_awaddr;
        w_sel_reg   <= decode(s_awaddr);
        aw_done_reg <= 1'b0;
        w_done_reg  <= 1'b0;
      end else if (w_state_reg == W_FWD) begin
        if (aw_hs) aw_done_reg <= 1'b1;
        if (w_hs)  w_done_reg  <= 1'b1;
      end
    end
  end

  always_comb begin
    w_state_next = w_state_reg;
    aw_hs        = 1'b0;
    w_hs         = 1'b0;
    s_awready    = 1'b0;
    s_wready     = 1'b0;
    s_bvalid     = 1'b0;
    s_bresp      = 2'b00;
    m0_awvalid   = 1'b0;
    m0_wvalid    = 1'b0;
    m0_bready    = 1'b0;
    m1_awvalid   = 1'b0;
    m1_wvalid    = 1'b0;
    m1_bready    = 1'b0;
    case (w_state_reg)
      W_IDLE: begin
        s_awready = 1'b1;
        if (s_awvalid) w_state_next = W_FWD;
      end
      W_FWD: begin
        // AW and W complete independently. The done flags keep each
        // channel from issuing a second beat while it waits for the other.
        case (w_sel_reg)
          SEL_M0: begin
            m0_awvalid = !aw_done_reg;
            m0_wvalid  = s_wvalid && !w_done_reg;
            s_wready   = m0_wready && !w_done_reg;
            aw_hs      = !aw_done_reg && m0_awready;
          end
          SEL_M1: begin
            m1_awvalid = !aw_done_reg;
            m1_wvalid  = s_wvalid && !w_done_reg;
            s_wready   = m1_wready && !w_done_reg;
            aw_hs      = !aw_done_reg && m1_awready;
          end
          default: begin
            // Unmapped: there is no downstream AW, and one W beat is sunk.
            aw_hs    = !aw_done_reg;
            s_wready = !w_done_reg;
          end
        endcase
        w_hs = s_wvalid && s_wready;
        if ((aw_done_reg || aw_hs) && (w_done_reg || w_hs)) w_state_next = W_RESP;
      end
      W_RESP: begin
        case (w_sel_reg)
          SEL_M0: begin
            s_bvalid  = m0_bvalid;
            s_bresp   = m0_bresp;
            m0_bready = s_bready;
          end
          SEL_M1: begin
            s_bvalid  = m1_bvalid;
            s_bresp   = m1_bresp;
            m1_bready = s_bready;
          end
          default: begin
            s_bvalid = 1'b1;
            s_bresp  = 2'b11;
          end
        endcase
        if (s_bvalid && s_bready) w_state_next = W_IDLE;
      end
      default: w_state_next = W_IDLE;
    endcase
  end

  // ---------------- read path ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state_reg <= R_IDLE;
      r_sel_reg   <= SEL_M0;
      araddr_reg  <= '0;
    end else begin
      r_state_reg <= r_state_next;
      if (r_state_reg == R_IDLE && s_arvalid) begin
        araddr_reg <= s_araddr;
        r_sel_reg  <= decode(s_araddr);
      end
    end
  end

  always_comb begin
    r_state_next = r_state_reg;
    s_arready    = 1'b0;
    s_rvalid     = 1'b0;
    s_rdata      = '0;
    s_rresp      = 2'b00;
    m0_arvalid   = 1'b0;
    m0_rready    = 1'b0;
    m1_arvalid   = 1'b0;
    m1_rready    = 1'b0;
    case (r_state_reg)
      R_IDLE: begin
        s_arready = 1'b1;
        // An unmapped read has nothing to forward, so it goes straight to
        // the response state.
        if (s_arvalid)
          r_state_next = (decode(s_araddr) == SEL_ERR) ? R_RESP : R_FWD;
      end
      R_FWD: begin
        case (r_sel_reg)
          SEL_M0: begin
            m0_arvalid = 1'b1;
            if (m0_arready) r_state_next = R_RESP;
          end
          SEL_M1: begin
            m1_arvalid = 1'b1;
            if (m1_arready) r_state_next = R_RESP;
          end
          default: r_state_next = R_RESP;
        endcase
      end
      R_RESP: begin
        case (r_sel_reg)
          SEL_M0: begin
            s_rvalid  = m0_rvalid;
            s_rdata   = m0_rdata;
            s_rresp   = m0_rresp;
            m0_rready = s_rready;
          end
          SEL_M1: begin
            s_rvalid  = m1_rvalid;
            s_rdata   = m1_rdata;
            s_rresp   = m1_rresp;
            m1_rready = s_rready;
          end
          default: begin
            s_rvalid = 1'b1;
            s_rresp  = 2'b11;
          end
        endcase
        if (s_rvalid && s_rready) r_state_next = R_IDLE;
      end
      default: r_state_next = R_IDLE;
    endcase
  end

endmodule

// File: tb/tb_axi_decoder.sv
// Testbench for axi_decoder. Two behavioural slaves answer on the downstream
// ports. A transaction-level scoreboard predicts where each write and read
// must arrive and what the upstream response must be.
module tb_axi_decoder;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset;

  logic        s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
  logic        s_arvalid, s_arready, s_rvalid, s_rready;
  logic [31:0] s_awaddr, s_wdata, s_araddr, s_rdata;
  logic [3:0]  s_wstrb;
  logic [1:0]  s_bresp, s_rresp;

  logic [1:0] m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
  logic [1:0] m_arvalid, m_arready, m_rvalid, m_rready;
  logic [1:0][31:0] m_awaddr, m_wdata, m_araddr, m_rdata;
  logic [1:0][3:0]  m_wstrb;
  logic [1:0][1:0]  m_bresp, m_rresp;

  axi_decoder dut (
    .clk(clk), .reset(reset),
    .s_awvalid(s_awvalid), .s_awaddr(s_awaddr), .s_awready(s_awready),
    .s_wvalid(s_wvalid), .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wready(s_wready),
    .s_bvalid(s_bvalid), .s_bresp(s_bresp), .s_bready(s_bready),
    .s_arvalid(s_arvalid), .s_araddr(s_araddr), .s_arready(s_arready),
    .s_rvalid(s_rvalid), .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rready(s_rready),
    .m0_awvalid(m_awvalid[0]), .m0_awaddr(m_awaddr[0]), .m0_awready(m_awready[0]),
    .m0_wvalid(m_wvalid[0]), .m0_wdata(m_wdata[0]), .m0_wstrb(m_wstrb[0]), .m0_wready(m_wready[0]),
    .m0_bvalid(m_bvalid[0]), .m0_bresp(m_bresp[0]), .m0_bready(m_bready[0]),
    .m0_arvalid(m_arvalid[0]), .m0_araddr(m_araddr[0]), .m0_arready(m_arready[0]),
    .m0_rvalid(m_rvalid[0]), .m0_rdata(m_rdata[0]), .m0_rresp(m_rresp[0]), .m0_rready(m_rready[0]),
    .m1_awvalid(m_awvalid[1]), .m1_awaddr(m_awaddr[1]), .m1_awready(m_awready[1]),
    .m1_wvalid(m_wvalid[1]), .m1_wdata(m_wdata[1]), .m1_wstrb(m_wstrb[1]), .m1_wready(m_wready[1]),
    .m1_bvalid(m_bvalid[1]), .m1_bresp(m_bresp[1]), .m1_bready(m_bready[1]),
    .m1_arvalid(m_arvalid[1]), .m1_araddr(m_araddr[1]), .m1_arready(m_arready[1]),
    .m1_rvalid(m_rvalid[1]), .m1_rdata(m_rdata[1]), .m1_rresp(m_rresp[1]), .m1_rready(m_rready[1])
  );

  int n_cmp = 0, n_bad = 0, cyc = 0, n_txn = 0;

  // slave model state
  int          aw_cnt[2], w_cnt[2], ar_cnt[2], first_awv[2];
  int          b_owed[2], r_owed[2];
  bit          b_act[2], r_act[2], b_sched[2];
  logic [31:0] aw_seen[2], w_seen[2], ar_seen[2], r_sent[2];
  logic [3:0]  strb_seen[2];
  logic [1:0]  b_sent[2], r_resp_sent[2];
  // stimulus controls
  bit          rnd_ready = 0, hold_bready = 0, use_fixed = 0, w_busy = 0;
  int          aw_hold = 0, w_tgt = 3;
  logic [31:0] r_fixed = 32'h0;
  // upstream observations
  bit          aw_acc, b_done, ar_acc, r_done;
  int          aw_acc_cyc, ar_acc_cyc;
  logic [1:0]  got_bresp, got_rresp;
  logic [31:0] got_rdata;

  function automatic bit coin();
    return $urandom_range(0, 1) == 1;
  endfunction

  // Address map: 64 KiB page 0 -> slave 0, page 1 -> slave 1, others unmapped.
  // The value 2 means "answered by the decoder itself".
  function automatic int tgt_of(input logic [31:0] a);
    int page;
    page = int'(a >> 16);
    if (page == 0) return 0;
    if (page == 1) return 1;
`ifdef AXI_DECODER_DECERR_EN
    return 2;
`else
    return 1;
`endif
  endfunction

  task automatic clear_txn();
    for (int i = 0; i < 2; i++) begin
      aw_cnt[i] = 0; w_cnt[i] = 0; ar_cnt[i] = 0; first_awv[i] = -1; b_sched[i] = 0;
    end
    aw_acc = 0; b_done = 0; ar_acc = 0; r_done = 0;
    aw_acc_cyc = -1; ar_acc_cyc = -1;
  endtask

  task automatic slaves_drive();
    for (int i = 0; i < 2; i++) begin
      m_awready[i] = (i == 0 && aw_hold > 0) ? 1'b0 : (rnd_ready ? coin() : 1'b1);
      m_wready[i]  = rnd_ready ? coin() : 1'b1;
      m_arready[i] = rnd_ready ? coin() : 1'b1;
      if (!b_act[i] && b_owed[i] > 0 && (!rnd_ready || coin())) begin
        b_act[i] = 1; b_owed[i]--;
        b_sent[i] = (rnd_ready && coin()) ? 2'b10 : 2'b00;
        m_bresp[i] = b_sent[i];
      end
      m_bvalid[i] = b_act[i];
      if (!r_act[i] && r_owed[i] > 0 && (!rnd_ready || coin())) begin
        r_act[i] = 1; r_owed[i]--;
        r_sent[i] = use_fixed ? r_fixed : $urandom;
        r_resp_sent[i] = (rnd_ready && coin()) ? 2'b10 : 2'b00;
        m_rdata[i] = r_sent[i]; m_rresp[i] = r_resp_sent[i];
      end
      m_rvalid[i] = r_act[i];
    end
    s_bready = hold_bready ? 1'b0 : (rnd_ready ? coin() : 1'b1);
    s_rready = rnd_ready ? coin() : 1'b1;
  endtask

  // One clock: drive slaves, settle, observe handshakes, advance to negedge.
  task automatic tick();
    bit aw_h, w_h, ar_h;
    slaves_drive();
    #1;
    n_cmp++;
    if (m_awvalid == 2'b11 || m_wvalid == 2'b11 || m_arvalid == 2'b11) begin
      n_bad++; $display("FAIL both_ports_valid cyc=%0d aw=%b w=%b ar=%b required only one", cyc, m_awvalid, m_wvalid, m_arvalid);
    end
    if (w_busy && !aw_acc) begin
      n_cmp++;
      if (s_wready !== 1'b0) begin
        n_bad++; $display("FAIL wready_before_aw cyc=%0d got=%b required=0", cyc, s_wready);
      end
    end
    if (s_bvalid && w_tgt < 2) begin
      n_cmp++;
      if (aw_cnt[w_tgt] == 0 || w_cnt[w_tgt] == 0) begin
        n_bad++; $display("FAIL bvalid_early cyc=%0d aw_cnt=%0d w_cnt=%0d required both 1", cyc, aw_cnt[w_tgt], w_cnt[w_tgt]);
      end
    end
    aw_h = s_awvalid && s_awready;
    w_h  = s_wvalid && s_wready;
    ar_h = s_arvalid && s_arready;
    if (aw_h) begin aw_acc = 1; aw_acc_cyc = cyc; end
    if (ar_h) begin ar_acc = 1; ar_acc_cyc = cyc; end
    if (s_bvalid && s_bready) begin b_done = 1; got_bresp = s_bresp; end
    if (s_rvalid && s_rready) begin r_done = 1; got_rdata = s_rdata; got_rresp = s_rresp; end
    for (int i = 0; i < 2; i++) begin
      if (m_awvalid[i] && first_awv[i] < 0) first_awv[i] = cyc;
      if (m_awvalid[i] && m_awready[i]) begin aw_cnt[i]++; aw_seen[i] = m_awaddr[i]; end
      if (m_wvalid[i] && m_wready[i]) begin w_cnt[i]++; w_seen[i] = m_wdata[i]; strb_seen[i] = m_wstrb[i]; end
      if (aw_cnt[i] > 0 && w_cnt[i] > 0 && !b_sched[i]) begin b_sched[i] = 1; b_owed[i]++; end
      if (m_bvalid[i] && m_bready[i]) b_act[i] = 0;
      if (m_arvalid[i] && m_arready[i]) begin ar_cnt[i]++; ar_seen[i] = m_araddr[i]; r_owed[i]++; end
      if (m_rvalid[i] && m_rready[i]) r_act[i] = 0;
    end
    @(posedge clk); @(negedge clk);
    cyc++;
    if (aw_hold > 0) aw_hold--;
    if (aw_h) s_awvalid = 0;
    if (w_h)  s_wvalid = 0;
    if (ar_h) s_arvalid = 0;
  endtask

  // Runs one write and/or one read, then scores it against the address map.
  task automatic run_txn(input bit do_w, input logic [31:0] waddr, input logic [31:0] wdata,
                         input logic [3:0] wstrb, input bit do_r, input logic [31:0] raddr,
                         input int w_lead);
    int start, tw, tr;
    clear_txn();
    tw = tgt_of(waddr); tr = tgt_of(raddr);
    w_tgt = do_w ? tw : 3; w_busy = do_w;
    s_awaddr = waddr; s_wdata = wdata; s_wstrb = wstrb; s_araddr = raddr;
    s_wvalid = do_w; s_awvalid = do_w && (w_lead == 0); s_arvalid = do_r;
    start = cyc;
    for (int k = 0; k < 300 && !((!do_w || b_done) && (!do_r || r_done)); k++) begin
      if (do_w && !aw_acc && !s_awvalid && cyc - start >= w_lead) s_awvalid = 1;
      tick();
    end
    w_busy = 0; w_tgt = 3;
    n_cmp++;
    if (!((!do_w || b_done) && (!do_r || r_done))) begin
      n_bad++; $display("FAIL timeout txn=%0d b_done=%0d r_done=%0d required done", n_txn, b_done, r_done);
      s_awvalid = 0; s_wvalid = 0; s_arvalid = 0;
    end
    if (do_w) begin
      if (tw < 2) begin
        n_cmp++;
        if (aw_cnt[tw] != 1 || aw_seen[tw] !== waddr || w_cnt[tw] != 1 || w_seen[tw] !== wdata || strb_seen[tw] !== wstrb) begin
          n_bad++; $display("FAIL wr_route txn=%0d slave=%0d aw_cnt=%0d addr=%h w_cnt=%0d data=%h strb=%h required 1 %h 1 %h %h",
                            n_txn, tw, aw_cnt[tw], aw_seen[tw], w_cnt[tw], w_seen[tw], strb_seen[tw], waddr, wdata, wstrb);
        end
        n_cmp++;
        if (aw_cnt[1-tw] + w_cnt[1-tw] != 0) begin
          n_bad++; $display("FAIL wr_other_idle txn=%0d slave=%0d beats=%0d required 0", n_txn, 1 - tw, aw_cnt[1-tw] + w_cnt[1-tw]);
        end
        n_cmp++;
        if (got_bresp !== b_sent[tw]) begin
          n_bad++; $display("FAIL bresp txn=%0d got=%b required=%b", n_txn, got_bresp, b_sent[tw]);
        end
        n_cmp++;
        if (first_awv[tw] - aw_acc_cyc != 1) begin
          n_bad++; $display("FAIL aw_latency txn=%0d got=%0d required=1", n_txn, first_awv[tw] - aw_acc_cyc);
        end
      end else begin
        n_cmp++;
        if (aw_cnt[0] + aw_cnt[1] + w_cnt[0] + w_cnt[1] != 0 || got_bresp !== 2'b11) begin
          n_bad++; $display("FAIL wr_decerr txn=%0d beats=%0d bresp=%b required 0 11", n_txn, aw_cnt[0] + aw_cnt[1] + w_cnt[0] + w_cnt[1], got_bresp);
        end
      end
      n_cmp++;
      if (aw_acc_cyc != start + w_lead) begin
        n_bad++; $display("FAIL aw_accept txn=%0d got_cyc=%0d required=%0d", n_txn, aw_acc_cyc, start + w_lead);
      end
    end
    if (do_r) begin
      if (tr < 2) begin
        n_cmp++;
        if (ar_cnt[tr] != 1 || ar_seen[tr] !== raddr || ar_cnt[1-tr] != 0) begin
          n_bad++; $display("FAIL rd_route txn=%0d slave=%0d ar_cnt=%0d addr=%h other=%0d required 1 %h 0", n_txn, tr, ar_cnt[tr], ar_seen[tr], ar_cnt[1-tr], raddr);
        end
        n_cmp++;
        if (got_rdata !== r_sent[tr] || got_rresp !== r_resp_sent[tr]) begin
          n_bad++; $display("FAIL rdata txn=%0d got=%h/%b required=%h/%b", n_txn, got_rdata, got_rresp, r_sent[tr], r_resp_sent[tr]);
        end
      end else begin
        n_cmp++;
        if (ar_cnt[0] + ar_cnt[1] != 0 || got_rdata !== 32'h0 || got_rresp !== 2'b11) begin
          n_bad++; $display("FAIL rd_decerr txn=%0d ar=%0d rdata=%h rresp=%b required 0 0 11", n_txn, ar_cnt[0] + ar_cnt[1], got_rdata, got_rresp);
        end
      end
      n_cmp++;
      if (ar_acc_cyc != start) begin
        n_bad++; $display("FAIL ar_accept txn=%0d got_cyc=%0d required=%0d", n_txn, ar_acc_cyc, start);
      end
    end
    $display("txn %0d: wr=%0d addr=%h data=%h bresp=%b | rd=%0d addr=%h rdata=%h rresp=%b",
             n_txn, do_w, waddr, wdata, got_bresp, do_r, raddr, got_rdata, got_rresp);
    n_txn++;
  endtask

  task automatic reset_models();
    for (int i = 0; i < 2; i++) begin
      b_owed[i] = 0; r_owed[i] = 0; b_act[i] = 0; r_act[i] = 0;
    end
    m_bvalid = '0; m_rvalid = '0; m_bresp = '0; m_rresp = '0; m_rdata = '0;
    m_awready = '0; m_wready = '0; m_arready = '0;
    s_awvalid = 0; s_wvalid = 0; s_arvalid = 0; s_bready = 0; s_rready = 0;
    s_awaddr = '0; s_wdata = '0; s_wstrb = '0; s_araddr = '0;
    clear_txn();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    reset_models();
    @(negedge clk); @(negedge clk); #1;
    n_cmp++;
    if ({m_awvalid, m_wvalid, m_arvalid, m_bready, m_rready, s_bvalid, s_rvalid} !== '0) begin
      n_bad++; $display("FAIL reset_outputs got=%b required=0", {m_awvalid, m_wvalid, m_arvalid, m_bready, m_rready, s_bvalid, s_rvalid});
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    n_cmp++;
    if (s_awready !== 1'b1 || s_arready !== 1'b1 || m_awaddr[0] !== 32'h0 || m_araddr[1] !== 32'h0) begin
      n_bad++; $display("FAIL reset_release awready=%b arready=%b awaddr=%h araddr=%h required 1 1 0 0", s_awready, s_arready, m_awaddr[0], m_araddr[1]);
    end
    @(negedge clk);
    $display("txn reset: checked outputs during and after reset");
  endtask

  task automatic test_write_m0();
    rnd_ready = 0;
    run_txn(1, 32'h0000_0010, 32'hA5A5_A5A5, 4'hF, 0, 32'h0, 0);
    n_cmp++;
    if (got_bresp !== 2'b00 || aw_cnt[1] != 0) begin
      n_bad++; $display("FAIL write_m0 bresp=%b m1_aw=%0d required 00 0", got_bresp, aw_cnt[1]);
    end
  endtask

  task automatic test_read_m1();
    rnd_ready = 0; use_fixed = 1; r_fixed = 32'h1234_5678;
    run_txn(0, 32'h0, 32'h0, 4'h0, 1, 32'h0001_0004, 0);
    use_fixed = 0;
    n_cmp++;
    if (got_rdata !== 32'h1234_5678 || got_rresp !== 2'b00 || ar_cnt[0] != 0) begin
      n_bad++; $display("FAIL read_m1 rdata=%h rresp=%b m0_ar=%0d required 12345678 00 0", got_rdata, got_rresp, ar_cnt[0]);
    end
  endtask

  task automatic test_w_before_aw();
    rnd_ready = 0; aw_hold = 8;
    run_txn(1, 32'h0000_0100, 32'hDEAD_BEEF, 4'h5, 0, 32'h0, 3);
    aw_hold = 0;
  endtask

  task automatic test_concurrent();
    rnd_ready = 0;
    run_txn(1, 32'h0000_0020, 32'h0BAD_F00D, 4'hF, 1, 32'h0001_0008, 0);
    n_cmp++;
    if (aw_acc_cyc != ar_acc_cyc) begin
      n_bad++; $display("FAIL concurrent_accept aw_cyc=%0d ar_cyc=%0d required equal", aw_acc_cyc, ar_acc_cyc);
    end
  endtask

  task automatic test_unmapped();
    rnd_ready = 0;
    run_txn(0, 32'h0, 32'h0, 4'h0, 1, 32'h0002_0000, 0);
    run_txn(1, 32'h0003_0040, 32'h5555_AAAA, 4'h3, 0, 32'h0, 0);
  endtask

  task automatic test_random();
    logic [31:0] a, b;
    bit dw, dr;
    rnd_ready = 1;
    for (int n = 0; n < 40; n++) begin
      a = {16'($urandom_range(0, 3)), 14'($urandom), 2'b00};
      b = {16'($urandom_range(0, 3)), 14'($urandom), 2'b00};
      if (n % 10 == 9) a[31:16] = 16'($urandom);
      dw = coin(); dr = coin();
      if (!dw && !dr) dw = 1;
      run_txn(dw, a, $urandom, 4'($urandom), dr, b, int'($urandom_range(0, 2)));
    end
  endtask

  task automatic test_back_to_back();
    rnd_ready = 0;
    for (int n = 0; n < 4; n++)
      run_txn(1, 32'(n * 32'h0000_8004), 32'(32'h1000 + n), 4'hF, 1, 32'(32'h0001_0000 + n * 4), 0);
  endtask

  task automatic test_reset_mid();
    rnd_ready = 0; hold_bready = 1;
    clear_txn();
    w_busy = 1; w_tgt = 0;
    s_awaddr = 32'h0000_0044; s_wdata = 32'hCAFE_0001; s_wstrb = 4'hF;
    s_awvalid = 1; s_wvalid = 1;
    for (int k = 0; k < 50 && !b_act[0]; k++) tick();
    w_busy = 0; w_tgt = 3;
    #1;
    n_cmp++;
    if (s_bvalid !== 1'b1) begin
      n_bad++; $display("FAIL pre_reset_bvalid got=%b required=1", s_bvalid);
    end
    reset = 1'b1;
    #1;
    n_cmp++;
    if (s_bvalid !== 1'b0 || m_bready !== 2'b00) begin
      n_bad++; $display("FAIL reset_mid_bvalid bvalid=%b bready=%b required 0 00", s_bvalid, m_bready);
    end
    @(posedge clk); @(negedge clk);
    reset_models();
    hold_bready = 0;
    reset = 1'b0;
    #1;
    n_cmp++;
    if (s_awready !== 1'b1 || s_arready !== 1'b1 || m_awvalid !== 2'b00) begin
      n_bad++; $display("FAIL reset_mid_release awready=%b arready=%b awvalid=%b required 1 1 00", s_awready, s_arready, m_awvalid);
    end
    @(negedge clk);
    $display("txn reset_mid: write dropped in response phase");
    run_txn(1, 32'h0000_0048, 32'hCAFE_0002, 4'hF, 0, 32'h0, 0);
  endtask

  initial begin
    test_reset();
    test_write_m0();
    test_read_m1();
    test_w_before_aw();
    test_concurrent();
    test_unmapped();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout time=%0t required completion", $time);
    $fatal(1, "global timeout");
  end
endmodule
